// File: rtl/alu_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of a shared combinational ALU.
// One operation in flight at a time: IDLE (accept) -> EXEC (drive ALU) -> RESP (return result).
module alu_arbiter #(
  parameter int WIDTH = 16,
  parameter int OPW   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  // requester 0
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_op1,
  input  logic [WIDTH-1:0] req0_op2,
  input  logic [OPW-1:0]   req0_alu_op,
  // requester 1
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_op1,
  input  logic [WIDTH-1:0] req1_op2,
  input  logic [OPW-1:0]   req1_alu_op,
  // responses
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_result,
  // ALU side
  output logic [WIDTH-1:0] alu_op1,
  output logic [WIDTH-1:0] alu_op2,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_result,
  // status
  output logic             busy,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             owner_q, owner_d;
  logic [WIDTH-1:0] op1_q, op1_d;
  logic [WIDTH-1:0] op2_q, op2_d;
  logic [OPW-1:0]   alu_op_q, alu_op_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic gnt_any;
  logic gnt_id;
  logic req_hs;
  logic rsp_hs;

  // Grant looks at valids only; on contention the port not served last wins.
  always_comb begin
    gnt_any = req0_valid | req1_valid;
    gnt_id  = 1'b0;
    if (req0_valid && req1_valid) begin
      gnt_id = ~last_grant_q;
    end else if (req1_valid) begin
      gnt_id = 1'b1;
    end
  end

  // Handshake rule on both channels: a transfer happens on a rising edge where
  // valid & ready are both high; valid/payload must stay stable until then.
  assign req0_ready = (state_q == ST_IDLE) & gnt_any & ~gnt_id;
  assign req1_ready = (state_q == ST_IDLE) & gnt_any &  gnt_id;
  assign req_hs     = (req0_valid & req0_ready) | (req1_valid & req1_ready);

  assign rsp0_valid = (state_q == ST_RESP) & ~owner_q;
  assign rsp1_valid = (state_q == ST_RESP) &  owner_q;
  assign rsp_hs     = (rsp0_valid & rsp0_ready) | (rsp1_valid & rsp1_ready);

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    op1_d        = op1_q;
    op2_d        = op2_q;
    alu_op_d     = alu_op_q;
    result_d     = result_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_hs) begin
          state_d      = ST_EXEC;
          owner_d      = gnt_id;
          last_grant_d = gnt_id;
          op1_d        = gnt_id ? req1_op1    : req0_op1;
          op2_d        = gnt_id ? req1_op2    : req0_op2;
          alu_op_d     = gnt_id ? req1_alu_op : req0_alu_op;
        end
      end
      ST_EXEC: begin
        result_d = alu_result;
        state_d  = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_hs) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      op1_q        <= '0;
      op2_q        <= '0;
      alu_op_q     <= '0;
      result_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      op1_q        <= op1_d;
      op2_q        <= op2_d;
      alu_op_q     <= alu_op_d;
      result_q     <= result_d;
    end
  end

  // The ALU sees the operand registers at all times, not just in EXEC.
  assign alu_op1    = op1_q;
  assign alu_op2    = op2_q;
  assign alu_op     = alu_op_q;
  assign rsp_result = result_q;
  assign busy       = (state_q != ST_IDLE);
  assign dbg_state  = state_q;

  a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    !(req0_ready && req1_ready));
  a_rsp_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    !(rsp0_valid && rsp1_valid));
  a_exec_to_resp: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == ST_EXEC) |=> (state_q == ST_RESP));

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed vector table, multi-cycle corner sequences,
// and random traffic checked per cycle by a transaction-level model.
module tb_alu_arbiter;

  localparam int W  = 16;
  localparam int OW = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic          req0_valid = 0, req1_valid = 0;
  logic          req0_ready, req1_ready;
  logic [W-1:0]  req0_op1 = 0, req0_op2 = 0, req1_op1 = 0, req1_op2 = 0;
  logic [OW-1:0] req0_alu_op = 0, req1_alu_op = 0;
  logic          rsp0_valid, rsp1_valid;
  logic          rsp0_ready = 1, rsp1_ready = 1;
  logic [W-1:0]  rsp_result, alu_op1, alu_op2, alu_result;
  logic [OW-1:0] alu_op;
  logic          busy;
  logic [1:0]    dbg_state;

  alu_arbiter #(.WIDTH(W), .OPW(OW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_op1(req0_op1), .req0_op2(req0_op2), .req0_alu_op(req0_alu_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_op1(req1_op1), .req1_op2(req1_op2), .req1_alu_op(req1_alu_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_op(alu_op),
    .alu_result(alu_result),
    .busy(busy), .dbg_state(dbg_state)
  );

  // Stand-in ALU: 0 ADD, 1 NAND, 2 SUB (non-commutative), others XOR.
  function automatic logic [W-1:0] ref_alu(input logic [OW-1:0] op,
                                           input logic [W-1:0] a, input logic [W-1:0] b);
    int unsigned s;
    case (op)
      3'd0: begin s = (int'(a) + int'(b)) % 65536; return W'(s); end
      3'd1: return ~(a & b);
      3'd2: begin s = (int'(a) + 65536 - int'(b)) % 65536; return W'(s); end
      default: return a ^ b;
    endcase
  endfunction

  assign alu_result = ref_alu(alu_op, alu_op1, alu_op2);

  // ---------------- checking ----------------
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard / reference model ----------------
  logic [W-1:0] exp_q[$];
  bit           own_q[$];
  bit           m_inflight = 0;
  bit           m_last = 1;
  int           m_age = 0;
  logic [W-1:0] m_a, m_b;
  logic [OW-1:0] m_op;

  always @(negedge clk) begin
    bit e_r0, e_r1, e_v0, e_v1, own;
    if (!rst_n) begin
      m_inflight = 0; m_last = 1; m_age = 0;
      exp_q.delete(); own_q.delete();
      chk("mon_rst_busy", busy, 0);
      chk("mon_rst_rsp0", rsp0_valid, 0);
      chk("mon_rst_rsp1", rsp1_valid, 0);
      chk("mon_rst_result", rsp_result, 0);
      chk("mon_rst_aluop1", alu_op1, 0);
    end else begin
      own  = (own_q.size() > 0) ? own_q[0] : 1'b0;
      e_r0 = !m_inflight && req0_valid && (!req1_valid || m_last == 1);
      e_r1 = !m_inflight && req1_valid && (!req0_valid || m_last == 0);
      e_v0 = m_inflight && m_age >= 1 && own == 0;
      e_v1 = m_inflight && m_age >= 1 && own == 1;
      chk("mon_req0_ready", req0_ready, e_r0);
      chk("mon_req1_ready", req1_ready, e_r1);
      chk("mon_busy", busy, m_inflight);
      chk("mon_rsp0_valid", rsp0_valid, e_v0);
      chk("mon_rsp1_valid", rsp1_valid, e_v1);
      if (m_inflight && m_age >= 1) chk("mon_rsp_result", rsp_result, exp_q[0]);
      if (m_inflight && m_age == 0) begin
        chk("mon_exec_op1", alu_op1, m_a);
        chk("mon_exec_op2", alu_op2, m_b);
        chk("mon_exec_op", alu_op, m_op);
      end
      if (e_r0 || e_r1) begin
        m_a  = e_r1 ? req1_op1 : req0_op1;
        m_b  = e_r1 ? req1_op2 : req0_op2;
        m_op = e_r1 ? req1_alu_op : req0_alu_op;
        exp_q.push_back(ref_alu(m_op, m_a, m_b));
        own_q.push_back(e_r1);
        m_last = e_r1; m_inflight = 1; m_age = 0;
      end else if (m_inflight) begin
        if ((e_v0 && rsp0_ready) || (e_v1 && rsp1_ready)) begin
          void'(exp_q.pop_front()); void'(own_q.pop_front());
          m_inflight = 0;
        end else begin
          m_age++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk); #2;
  endtask

  task automatic do_reset();
    req0_valid = 0; req1_valid = 0;
    @(posedge clk); #2;
    rst_n = 0;
    cyc(); cyc();
    rst_n = 1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk("wait_idle_timeout", busy, 0);
    cyc();
  endtask

  task automatic drive(input bit port, input logic [OW-1:0] op,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    if (port) begin
      req1_valid = 1; req1_alu_op = op; req1_op1 = a; req1_op2 = b;
    end else begin
      req0_valid = 1; req0_alu_op = op; req0_op1 = a; req0_op2 = b;
    end
  endtask

  function automatic logic [W-1:0] rand_val();
    logic [W-1:0] corner[5];
    corner[0] = 16'h0000; corner[1] = 16'hFFFF; corner[2] = 16'h8000;
    corner[3] = 16'h7FFF; corner[4] = 16'h0001;
    if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 4)];
    return W'($urandom);
  endfunction

  typedef struct {
    bit            port;
    logic [OW-1:0] op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [W-1:0]  exp;
  } vec_t;

  vec_t vecs[8];

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog no_finish actual=%0d expected=finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin : main
    bit g0, g1, hs0, hs1;
    bit glog[$];

    vecs[0] = '{0, 3'd0, 16'h0005, 16'h0003, 16'h0008};
    vecs[1] = '{1, 3'd1, 16'hFFFF, 16'h00FF, 16'hFF00};
    vecs[2] = '{0, 3'd1, 16'h0000, 16'h0000, 16'hFFFF};
    vecs[3] = '{1, 3'd0, 16'hFFFF, 16'h0001, 16'h0000};
    vecs[4] = '{0, 3'd2, 16'h0010, 16'h0003, 16'h000D};
    vecs[5] = '{1, 3'd2, 16'h0003, 16'h0010, 16'hFFF3};
    vecs[6] = '{0, 3'd5, 16'hAAAA, 16'h0F0F, 16'hA5A5};
    vecs[7] = '{1, 3'd0, 16'h7FFF, 16'h0001, 16'h8000};

    // reset state
    #1 rst_n = 0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_rsp0_valid", rsp0_valid, 0);
    chk("rst_rsp1_valid", rsp1_valid, 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_alu_op1", alu_op1, 0);
    chk("rst_alu_op2", alu_op2, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_req0_ready_idle", req0_ready, 0);
    #1 req0_valid = 1;
    #1 chk("rst_req0_ready_valid", req0_ready, 1);
    chk("rst_req1_ready_valid", req1_ready, 0);
    req0_valid = 0;
    cyc(); cyc();
    rst_n = 1;

    // directed vector table
    foreach (vecs[i]) begin
      wait_idle();
      drive(vecs[i].port, vecs[i].op, vecs[i].a, vecs[i].b);
      @(negedge clk);
      chk("vec_ready", vecs[i].port ? req1_ready : req0_ready, 1);
      cyc();
      req0_valid = 0; req1_valid = 0;
      @(negedge clk);
      chk("vec_exec_busy", busy, 1);
      chk("vec_exec_alu_op", alu_op, vecs[i].op);
      chk("vec_exec_alu_op1", alu_op1, vecs[i].a);
      cyc();
      @(negedge clk);
      chk("vec_rsp_valid", vecs[i].port ? rsp1_valid : rsp0_valid, 1);
      chk("vec_rsp_other", vecs[i].port ? rsp0_valid : rsp1_valid, 0);
      chk("vec_rsp_result", rsp_result, vecs[i].exp);
      chk("vec_rsp_busy", busy, 1);
      cyc();
      @(negedge clk);
      chk("vec_done_idle", busy, 0);
    end

    // contention right after reset: port 0 first, then port 1 three cycles later
    do_reset();
    drive(0, 3'd0, 16'h0001, 16'h0001);
    drive(1, 3'd0, 16'hFFFF, 16'h0001);
    @(negedge clk);
    chk("cont_req0_ready", req0_ready, 1);
    chk("cont_req1_ready", req1_ready, 0);
    cyc(); req0_valid = 0;
    @(negedge clk); chk("cont_req1_blocked", req1_ready, 0);
    cyc();
    @(negedge clk);
    chk("cont_rsp0_valid", rsp0_valid, 1);
    chk("cont_rsp0_result", rsp_result, 16'h0002);
    cyc();
    @(negedge clk); chk("cont_req1_ready_t3", req1_ready, 1);
    cyc(); req1_valid = 0;
    cyc();
    @(negedge clk);
    chk("cont_rsp1_valid", rsp1_valid, 1);
    chk("cont_rsp1_result", rsp_result, 16'h0000);
    cyc();

    // continuous contention: grants alternate
    do_reset();
    drive(0, OW'($urandom_range(0, 7)), rand_val(), rand_val());
    drive(1, OW'($urandom_range(0, 7)), rand_val(), rand_val());
    for (int c = 0; c < 60 && glog.size() < 6; c++) begin
      @(negedge clk);
      g0 = req0_valid && req0_ready;
      g1 = req1_valid && req1_ready;
      if (g0) glog.push_back(1'b0);
      if (g1) glog.push_back(1'b1);
      cyc();
      if (g0) drive(0, OW'($urandom_range(0, 7)), rand_val(), rand_val());
      if (g1) drive(1, OW'($urandom_range(0, 7)), rand_val(), rand_val());
    end
    req0_valid = 0; req1_valid = 0;
    chk("alt_count", glog.size(), 6);
    for (int i = 0; i < 6; i++) begin
      chk("alt_order", (i < glog.size()) ? 32'(glog[i]) : 32'd2, i % 2);
    end

    // response stall on port 0 with port 1 waiting
    wait_idle();
    rsp0_ready = 0;
    drive(0, 3'd0, 16'h1234, 16'h1111);
    @(negedge clk); chk("stall_req0_ready", req0_ready, 1);
    cyc(); req0_valid = 0;
    drive(1, 3'd1, 16'h0F0F, 16'h00FF);
    cyc();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_rsp0_valid", rsp0_valid, 1);
      chk("stall_rsp_result", rsp_result, 16'h2345);
      chk("stall_req1_ready", req1_ready, 0);
      cyc();
    end
    rsp0_ready = 1;
    @(negedge clk); chk("stall_release_valid", rsp0_valid, 1);
    cyc();
    @(negedge clk); chk("stall_req1_granted", req1_ready, 1);
    cyc(); req1_valid = 0;
    cyc(); cyc();

    // reset during EXEC
    wait_idle();
    drive(0, 3'd0, 16'h0007, 16'h0008);
    @(negedge clk);
    cyc(); req0_valid = 0;
    #1 chk("rexec_busy_before", busy, 1);
    rst_n = 0;
    #1;
    chk("rexec_busy", busy, 0);
    chk("rexec_rsp0", rsp0_valid, 0);
    chk("rexec_req0_ready", req0_ready, 0);
    chk("rexec_req1_ready", req1_ready, 0);
    chk("rexec_alu_op1", alu_op1, 0);
    cyc(); cyc();
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rexec_no_rsp", rsp0_valid | rsp1_valid, 0);
      cyc();
    end
    drive(0, 3'd0, 16'h0100, 16'h0023);
    drive(1, 3'd1, 16'h0000, 16'h0000);
    @(negedge clk);
    chk("rexec_port0_prio", req0_ready, 1);
    cyc(); req0_valid = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      g1 = req1_valid && req1_ready;
      cyc();
      if (g1) break;
    end
    req1_valid = 0;

    // random traffic against the model
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      hs0 = req0_valid && req0_ready;
      hs1 = req1_valid && req1_ready;
      cyc();
      if (hs0 || !req0_valid) begin
        req0_valid = ($urandom_range(0, 99) < 50);
        req0_alu_op = OW'($urandom_range(0, 7)); req0_op1 = rand_val(); req0_op2 = rand_val();
      end
      if (hs1 || !req1_valid) begin
        req1_valid = ($urandom_range(0, 99) < 50);
        req1_alu_op = OW'($urandom_range(0, 7)); req1_op1 = rand_val(); req1_op2 = rand_val();
      end
      rsp0_ready = ($urandom_range(0, 99) < 70);
      rsp1_ready = ($urandom_range(0, 99) < 70);
    end
    @(negedge clk);
    cyc();
    req0_valid = 0; req1_valid = 0; rsp0_ready = 1; rsp1_ready = 1;
    wait_idle();
    repeat (3) cyc();
    chk("final_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
